// File: rtl/mem_port_arbiter_pkg.sv
//==============================================================================
// Module      : mem_port_arbiter_pkg
// Description : Shared pipeline definitions for the memory port arbiter:
//               arbiter state encoding, data-streak default and a width helper.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package mem_port_arbiter_pkg;

    // Consecutive data grants tolerated while a fetch is waiting.
    localparam int MAX_D_STREAK_DEFAULT = 4;

    // Arbiter states: idle, fetch access in progress, data access in progress.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arbState_t;

    // Counter width able to hold 0..maxCount, never narrower than one bit.
    function automatic int streakWidth(input int maxCount);
        return (maxCount < 1) ? 1 : $clog2(maxCount + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter_starve_counter.sv
//==============================================================================
// Module      : starve_counter
// Description : Saturating count of back-to-back data grants taken while a
//               fetch is pending. Flags when the fetch must win arbitration.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module starve_counter
    import mem_port_arbiter_pkg::*;
#(
    parameter int MAX_COUNT = MAX_D_STREAK_DEFAULT,
    parameter int CNT_W     = streakWidth(MAX_COUNT)
) (
    input  logic clk,
    input  logic rst,
    input  logic incEn,
    input  logic clr,
    output logic atMax
);

    localparam logic [CNT_W-1:0] c_MAX_CNT = CNT_W'(MAX_COUNT);

    logic [CNT_W-1:0] r_cnt;

    // Clear has priority over increment; the count parks at the limit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (incEn && (r_cnt != c_MAX_CNT)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign atMax = (r_cnt == c_MAX_CNT);

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
//==============================================================================
// Module      : mem_port_arbiter
// Description : Single-port memory arbiter between instruction fetch and data
//               access. Data normally wins; a fetch is forced through after
//               MAX_D_STREAK consecutive data grants. Fetch results can be
//               dropped by a branch flush.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int MAX_D_STREAK = MAX_D_STREAK_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [DATA_W-1:0] if_addr,
    input  logic              branch_taken,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [DATA_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] if_instr,
    output logic              if_valid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_valid,
    output logic              freeze_if,
    output logic              stall_mem
);

    arbState_t         r_state;
    arbState_t         w_nextState;
    logic              w_grantI;
    logic              w_grantD;
    logic              w_streakAtMax;
    logic              r_drop;
    logic              r_memWe;
    logic [DATA_W-1:0] r_memAddr;
    logic [DATA_W-1:0] r_memWdata;
    logic              r_ifValid;
    logic [DATA_W-1:0] r_ifInstr;
    logic              r_dValid;
    logic [DATA_W-1:0] r_dRdata;

    // Streak of data grants taken at the expense of a waiting fetch.
    starve_counter #(
        .MAX_COUNT (MAX_D_STREAK)
    ) u_starve_counter (
        .clk   (clk),
        .rst   (rst),
        .incEn (w_grantD & if_req),
        .clr   (~if_req | w_grantI),
        .atMax (w_streakAtMax)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Arbitration and completion: data first unless the fetch has starved.
    always_comb begin
        w_nextState = r_state;
        w_grantI    = 1'b0;
        w_grantD    = 1'b0;
        case (r_state)
            IDLE: begin
                if (d_req && !(if_req && w_streakAtMax)) begin
                    w_grantD    = 1'b1;
                    w_nextState = BUSY_D;
                end else if (if_req) begin
                    w_grantI    = 1'b1;
                    w_nextState = BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                if (mem_ready) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Access attributes latched at grant, held stable for the whole access.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_memAddr  <= '0;
            r_memWe    <= 1'b0;
            r_memWdata <= '0;
        end else if (w_grantD) begin
            r_memAddr  <= d_addr;
            r_memWe    <= d_we;
            r_memWdata <= d_wdata;
        end else if (w_grantI) begin
            r_memAddr  <= if_addr;
            r_memWe    <= 1'b0;
            r_memWdata <= '0;
        end
    end

    // A flush during a fetch (or on its completion cycle) discards the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop <= 1'b0;
        end else if (r_state == BUSY_I) begin
            r_drop <= mem_ready ? 1'b0 : (r_drop | branch_taken);
        end else begin
            r_drop <= 1'b0;
        end
    end

    // Completion pulses with read data captured; data outputs hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ifValid <= 1'b0;
            r_ifInstr <= '0;
            r_dValid  <= 1'b0;
            r_dRdata  <= '0;
        end else begin
            r_ifValid <= 1'b0;
            r_dValid  <= 1'b0;
            if ((r_state == BUSY_I) && mem_ready && !r_drop && !branch_taken) begin
                r_ifValid <= 1'b1;
                r_ifInstr <= mem_rdata;
            end
            if ((r_state == BUSY_D) && mem_ready) begin
                r_dValid <= 1'b1;
                r_dRdata <= mem_rdata;
            end
        end
    end

    assign mem_req   = (r_state != IDLE);
    assign mem_we    = r_memWe;
    assign mem_addr  = r_memAddr;
    assign mem_wdata = r_memWdata;
    assign if_valid  = r_ifValid;
    assign if_instr  = r_ifInstr;
    assign d_valid   = r_dValid;
    assign d_rdata   = r_dRdata;
    assign freeze_if = if_req & ~r_ifValid;
    assign stall_mem = d_req & ~r_dValid;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
//==============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed bench for mem_port_arbiter with a behavioural
//               reference model compared every cycle.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_mem_port_arbiter;

    localparam int DW   = 32;
    localparam int MAXS = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req;
    logic [DW-1:0] if_addr;
    logic          branch_taken;
    logic          d_req;
    logic          d_we;
    logic [DW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;
    logic          mem_req;
    logic          mem_we;
    logic [DW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] if_instr;
    logic          if_valid;
    logic [DW-1:0] d_rdata;
    logic          d_valid;
    logic          freeze_if;
    logic          stall_mem;

    int nVec = 0;
    int nMis = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .DATA_W       (DW),
        .MAX_D_STREAK (MAXS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .if_req       (if_req),
        .if_addr      (if_addr),
        .branch_taken (branch_taken),
        .d_req        (d_req),
        .d_we         (d_we),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ready    (mem_ready),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .if_instr     (if_instr),
        .if_valid     (if_valid),
        .d_rdata      (d_rdata),
        .d_valid      (d_valid),
        .freeze_if    (freeze_if),
        .stall_mem    (stall_mem)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nMis++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] memData(input logic [31:0] a);
        if (a == 32'h8) return 32'hE3A01005;
        return a ^ 32'h5A5A_0000;
    endfunction

    // Memory responder: ready after rspDelay busy cycles; optional stray ready.
    int rspDelay = 0;
    bit stray    = 1'b0;
    int busyCnt  = 0;
    always @(negedge clk) begin
        #1;
        if (mem_req) begin
            mem_ready = (busyCnt >= rspDelay);
            mem_rdata = memData(mem_addr);
            busyCnt++;
        end else begin
            busyCnt   = 0;
            mem_ready = stray;
            mem_rdata = 32'hDEAD_BEEF;
        end
    end

    // Reference model: 0 = no access, 1 = fetch access, 2 = data access.
    int          mBusy = 0;
    logic [31:0] mAddr = 0, mWdata = 0, mIfI = 0, mDR = 0;
    bit          mWe = 0, mDrop = 0, mIfV = 0, mDV = 0;
    int          mStreak = 0;

    always @(posedge clk) begin
        bit          sRst, sIfReq, sDReq, sDWe, sBr, sReady, gI, gD;
        logic [31:0] sIfAddr, sDAddr, sDWdata, sRdata;
        sRst = rst; sIfReq = if_req; sDReq = d_req; sDWe = d_we; sBr = branch_taken;
        sReady = mem_ready; sIfAddr = if_addr; sDAddr = d_addr; sDWdata = d_wdata;
        sRdata = mem_rdata; gI = 0; gD = 0;
        if (sRst) begin
            mBusy = 0; mAddr = 0; mWe = 0; mWdata = 0; mStreak = 0;
            mDrop = 0; mIfV = 0; mDV = 0; mIfI = 0; mDR = 0;
        end else begin
            mIfV = 0; mDV = 0;
            if (mBusy == 1) begin
                if (sReady) begin
                    if (!mDrop && !sBr) begin mIfV = 1; mIfI = sRdata; end
                    mDrop = 0; mBusy = 0;
                end else if (sBr) mDrop = 1;
            end else if (mBusy == 2) begin
                if (sReady) begin mDV = 1; mDR = sRdata; mBusy = 0; end
            end else begin
                if (sDReq && !(sIfReq && mStreak == MAXS)) begin
                    gD = 1; mBusy = 2; mAddr = sDAddr; mWe = sDWe; mWdata = sDWdata;
                end else if (sIfReq) begin
                    gI = 1; mBusy = 1; mAddr = sIfAddr; mWe = 0; mWdata = 0;
                end
            end
            if (!sIfReq || gI) mStreak = 0;
            else if (gD && mStreak < MAXS) mStreak = mStreak + 1;
        end
        #1;
        chk("mem_req", mem_req, mBusy != 0);
        if (mBusy != 0 || sRst) begin
            chk("mem_addr", mem_addr, mAddr);
            chk("mem_we", mem_we, mWe);
            chk("mem_wdata", mem_wdata, mWdata);
        end
        chk("if_valid", if_valid, mIfV);
        chk("d_valid", d_valid, mDV);
        chk("if_instr", if_instr, mIfI);
        chk("d_rdata", d_rdata, mDR);
        chk("freeze_if", freeze_if, if_req & ~mIfV);
        chk("stall_mem", stall_mem, d_req & ~mDV);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int dCnt, dBefore, cyc;
        bit ifDone;
        rst = 1; if_req = 0; if_addr = 0; branch_taken = 0; d_req = 0; d_we = 0;
        d_addr = 0; d_wdata = 0; mem_ready = 0; mem_rdata = 0;
        repeat (3) @(negedge clk);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_if_valid", if_valid, 0);
        chk("rst_d_rdata", d_rdata, 0);
        rst = 0;
        @(negedge clk);

        // Plain fetch, minimum latency.
        if_addr = 32'h8; if_req = 1;
        #1 chk("s1_freeze_t", freeze_if, 1);
        @(negedge clk);
        chk("s1_freeze_t1", freeze_if, 1);
        chk("s1_busy_addr", mem_addr, 32'h8);
        @(negedge clk);
        chk("s1_if_valid_t2", if_valid, 1);
        chk("s1_if_instr", if_instr, 32'hE3A01005);
        if_req = 0;

        // Simultaneous requests: data first, fetch right after.
        if_addr = 32'h200; if_req = 1; d_addr = 32'h40; d_we = 0; d_req = 1;
        @(negedge clk);
        chk("s2_first_is_data", mem_addr, 32'h40);
        @(negedge clk);
        chk("s2_d_valid", d_valid, 1);
        chk("s2_d_rdata", d_rdata, 32'h5A5A_0040);
        d_req = 0;
        @(negedge clk);
        chk("s2_fetch_busy", mem_req, 1);
        chk("s2_fetch_addr", mem_addr, 32'h200);
        @(negedge clk);
        chk("s2_if_instr", if_instr, 32'h5A5A_0200);
        if_req = 0;

        // Starvation limit: fetch forced after MAXS data grants.
        @(negedge clk);
        if_addr = 32'h300; if_req = 1; d_addr = 32'h80; d_req = 1;
        dCnt = 0; dBefore = -1; ifDone = 0; cyc = 0;
        while ((dCnt < 6 || !ifDone) && cyc < 60) begin
            @(negedge clk); cyc++;
            if (d_valid) dCnt++;
            if (if_valid) begin dBefore = dCnt; ifDone = 1; if_req = 0; end
            if (dCnt == 6) d_req = 0;
        end
        chk("s3_data_before_fetch", dBefore, 4);
        chk("s3_data_total", dCnt, 6);
        chk("s3_fetch_done", ifDone, 1);
        d_req = 0; if_req = 0;

        // Flush during a slow fetch, then a normal fetch.
        @(negedge clk);
        rspDelay = 2; if_addr = 32'h400; if_req = 1;
        @(negedge clk); branch_taken = 1;
        @(negedge clk); branch_taken = 0; if_req = 0;
        repeat (4) begin @(negedge clk); chk("s4_no_if_valid", if_valid, 0); end
        rspDelay = 0; if_addr = 32'h100; if_req = 1;
        @(negedge clk); chk("s4_new_addr", mem_addr, 32'h100);
        @(negedge clk);
        chk("s4_new_valid", if_valid, 1);
        chk("s4_new_instr", if_instr, 32'h5A5A_0100);
        if_req = 0;

        // Flush on the completion cycle itself.
        @(negedge clk); if_addr = 32'h500; if_req = 1;
        @(negedge clk); branch_taken = 1;
        @(negedge clk); branch_taken = 0; if_req = 0;
        chk("s4b_no_valid", if_valid, 0);
        chk("s4b_idle", mem_req, 0);
        chk("s4b_instr_hold", if_instr, 32'h5A5A_0100);

        // Flush during a data access has no effect.
        d_addr = 32'hC0; d_we = 0; d_req = 1; branch_taken = 1;
        @(negedge clk);
        @(negedge clk);
        chk("s4c_d_valid", d_valid, 1);
        chk("s4c_d_rdata", d_rdata, 32'h5A5A_00C0);
        d_req = 0; branch_taken = 0;

        // Stray ready while idle is ignored.
        @(negedge clk); stray = 1;
        repeat (3) begin
            @(negedge clk);
            chk("s5_stray_req", mem_req, 0);
            chk("s5_stray_valid", if_valid | d_valid, 0);
        end
        stray = 0;

        // Store held stable over a multi-cycle access.
        @(negedge clk);
        rspDelay = 2; d_we = 1; d_addr = 32'h20; d_wdata = 32'h55; d_req = 1;
        repeat (3) begin
            @(negedge clk);
            chk("s6_we", mem_we, 1);
            chk("s6_wdata", mem_wdata, 32'h55);
            chk("s6_addr", mem_addr, 32'h20);
        end
        @(negedge clk);
        chk("s6_d_valid", d_valid, 1);
        d_req = 0; d_we = 0;

        // Reset in the middle of a data access, then a stray ready.
        @(negedge clk);
        rspDelay = 5; d_addr = 32'h60; d_wdata = 32'h77; d_we = 1; d_req = 1;
        @(negedge clk);
        @(negedge clk);
        chk("s7_busy", mem_req, 1);
        rst = 1; d_req = 0; d_we = 0;
        @(negedge clk);
        rst = 0; stray = 1;
        chk("s7_req0", mem_req, 0);
        chk("s7_we0", mem_we, 0);
        chk("s7_addr0", mem_addr, 0);
        chk("s7_wdata0", mem_wdata, 0);
        chk("s7_instr0", if_instr, 0);
        chk("s7_rdata0", d_rdata, 0);
        repeat (3) begin
            @(negedge clk);
            chk("s7_no_valid", d_valid, 0);
            chk("s7_idle", mem_req, 0);
        end
        stray = 0;
        rspDelay = 0;

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule

`default_nettype wire
